// File: rtl/muldiv_div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int DIV_ITERS = 32;

    localparam logic [DATA_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN       = 32'h8000_0000;

    // funct3[1:0] encodings of the four divide instructions
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } div_state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_div_unit_if.sv
// Request and response handshakes between issue, the divider and writeback.
// Both directions use valid/ready: a transfer happens on a clock edge where
// valid and ready are both high; the sender holds its payload stable while
// valid is high and ready is low, and valid never waits on ready.
interface muldiv_div_unit_if
    import muldiv_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [1:0]        i_op;
    logic [DATA_W-1:0] i_rs1;
    logic [DATA_W-1:0] i_rs2;
    logic [TAG_W-1:0]  i_rd_addr;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_result;
    logic [TAG_W-1:0]  o_rd_addr;

    // Issue/writeback side
    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_rd_addr, i_ready,
        input  o_ready, o_valid, o_result, o_rd_addr
    );

    // Divider side
    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_rd_addr, i_ready,
        output o_ready, o_valid, o_result, o_rd_addr
    );
endinterface

// File: rtl/muldiv_div_unit_adder.sv
// 32-bit adder/subtractor shared by the divider: sel=1 gives a - b with
// carry_out=1 meaning no borrow (a >= b unsigned).
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] sum,
    output logic        carry_out
);
    logic [31:0] b_eff;

    // Invert b and inject a carry for subtraction
    always_comb begin
        b_eff = sel ? ~b : b;
        {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + 33'(sel);
    end
endmodule

// File: rtl/muldiv_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. Operands are made
// non-negative first, 32 restore steps produce quotient and remainder,
// then the selected value is sign-corrected through the same adder.
module muldiv_div_unit
    import muldiv_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    muldiv_div_unit_if.slave  bus,
    output logic              o_busy,
    output div_state_e        o_state
);
    div_state_e        state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] result_q;
    logic [TAG_W-1:0]  tag_q;
    logic [4:0]        count_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              valid_q;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_sel;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    logic [DATA_W-1:0] rs_shift;
    logic              success;
    logic [DATA_W-1:0] fix_val;
    logic              fix_neg;
    logic              div_zero;
    logic              ovf;
    logic [DATA_W-1:0] special_val;

    adder_32bit u_adder (
        .a         (add_a),
        .b         (add_b),
        .sel       (add_sel),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Restore-step operand, success flag, final selection and special cases
    always_comb begin
        rs_shift = {rem_q[DATA_W-2:0], dvd_q[count_q]};
        // A set msb means the shifted remainder already exceeds any divisor
        success  = rem_q[DATA_W-1] | add_cout;
        fix_val  = is_rem_op(op_q) ? rem_q : quo_q;
        fix_neg  = is_signed_op(op_q) &
                   (is_rem_op(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q));
        div_zero = (bus.i_rs2 == '0);
        ovf      = is_signed_op(bus.i_op) && (bus.i_rs1 == INT_MIN) &&
                   (bus.i_rs2 == '1);
        if (div_zero) begin
            special_val = is_rem_op(bus.i_op) ? bus.i_rs1 : DIV_BY_ZERO_Q;
        end else begin
            special_val = is_rem_op(bus.i_op) ? '0 : INT_MIN;
        end
    end

    // Adder operand mux; inputs are parked at zero when the adder is unused
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sel = 1'b0;
        case (state)
            ABS_A: begin
                add_b   = dvd_q;
                add_sel = 1'b1;
            end
            ABS_B: begin
                add_b   = dvs_q;
                add_sel = 1'b1;
            end
            ITER: begin
                add_a   = rs_shift;
                add_b   = dvs_q;
                add_sel = 1'b1;
            end
            FIX: begin
                add_b   = fix_val;
                add_sel = 1'b1;
            end
            default: begin
                add_sel = 1'b0;
            end
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
            count_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (i_flush) begin
            state   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        op_q     <= bus.i_op;
                        dvd_q    <= bus.i_rs1;
                        dvs_q    <= bus.i_rs2;
                        tag_q    <= bus.i_rd_addr;
                        sign_a_q <= is_signed_op(bus.i_op) & bus.i_rs1[DATA_W-1];
                        sign_b_q <= is_signed_op(bus.i_op) & bus.i_rs2[DATA_W-1];
                        if (div_zero || ovf) begin
                            result_q <= special_val;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ABS_A;
                        end
                    end
                end
                ABS_A: begin
                    if (sign_a_q) dvd_q <= add_sum;
                    state <= ABS_B;
                end
                ABS_B: begin
                    if (sign_b_q) dvs_q <= add_sum;
                    rem_q   <= '0;
                    quo_q   <= '0;
                    count_q <= 5'(DIV_ITERS - 1);
                    state   <= ITER;
                end
                ITER: begin
                    rem_q <= success ? add_sum : rs_shift;
                    // Quotient bits arrive msb first, so shifting in lands q[count]
                    quo_q <= {quo_q[DATA_W-2:0], success};
                    if (count_q == '0) begin
                        state <= FIX;
                    end else begin
                        count_q <= count_q - 5'd1;
                    end
                end
                FIX: begin
                    result_q <= fix_neg ? add_sum : fix_val;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready   = (state == IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_result  = result_q;
    assign bus.o_rd_addr = tag_q;
    assign o_busy        = (state != IDLE);
    assign o_state       = state;

endmodule

// File: doc/muldiv_div_unit.md
Name: muldiv_div_unit

Overview:
- Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the ALU and drives one shared adder_32bit instance, which it feeds and whose result it consumes every cycle.
- Accepts operands from decode/issue with a valid/ready handshake.
- Returns a tagged 32-bit result to writeback with a valid/ready handshake.

Parameters:
- DATA_W, 32, operand and result width; fixed by the adder width and not overridable.
- TAG_W, 5, width of the destination-register tag carried through the unit.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_flush  in  1  abort any in-flight operation
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request; high only in IDLE
- i_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_rs1  in  32  dividend
- i_rs2  in  32  divisor
- i_rd_addr  in  TAG_W  destination tag
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_result  out  32  quotient or remainder
- o_rd_addr  out  TAG_W  tag returned with the result
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values: on a rising edge with i_rst_n=0, state=IDLE and all of o_valid, o_busy, o_result, o_rd_addr and the internal registers are 0. o_ready=1 in the first cycle after reset.
- Reset priority: reset has priority over i_flush and over the handshakes. Reset mid-operation discards the operation with no output.
- Accept rule:
  - A request is accepted on an edge where i_valid & o_ready.
  - On accept, op, rs1, rs2 and tag are captured. Inputs are ignored at all other times.
- States: IDLE, ABS_A, ABS_B, ITER, FIX, DONE.
- IDLE -> DONE (special cases, resolved on accept):
  - Divisor = 0: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- IDLE -> ABS_A: all other requests.
- ABS_A: adder computes 0 - rs1 (sel=1). Keep |rs1| if the op is signed and rs1[31]=1, else rs1. -> ABS_B.
- ABS_B: same treatment of rs2. Clear the 32-bit partial remainder R and set count=31. -> ITER.
- ITER, each cycle:
  - {msb, Rs} = {R, dividend[count]}.
  - Adder computes Rs - divisor (sel=1).
  - Success = msb | CarryOut. If success, R <= adder OUT, else R <= Rs.
  - Quotient bit q[count] = success.
  - Stay in ITER while count != 0 and decrement count. -> FIX after the count=0 iteration, 32 iterations in total.
- FIX:
  - Select the quotient for DIV/DIVU, or R for REM/REMU.
  - Negate it via the adder when negation is needed:
    - DIV: signed op and rs1[31] != rs2[31].
    - REM: signed op and rs1[31] = 1.
  - Load o_result. -> DONE.
- DONE:
  - o_valid=1; o_result and o_rd_addr are held stable.
  - When i_ready=1 at an edge, go to IDLE with o_valid=0.
  - A new request cannot be accepted in the same edge as the DONE handshake.
- Latency: with the accept edge at cycle T, o_valid rises at T+36 for normal ops and at T+1 for special cases. Throughput is one operation per 37 cycles minimum.
- i_flush: from any state, at the next edge go to IDLE with o_valid=0. An active flush in IDLE blocks accept that cycle.
- Adder use: the adder is driven only by this unit. Its inputs are don't-care in IDLE and DONE.

Decomposition:
- Package muldiv_pkg:
  - state enum div_state_e.
  - op encodings OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - constants DIV_ITERS=32, DIV_BY_ZERO_Q=32'hFFFF_FFFF, INT_MIN=32'h8000_0000.
- Sub-module: one adder_32bit instance, with A/B/sel muxed by state.
- FSM and datapath stay in a single module.

Test Plan:
- DIVU 100 / 7 -> o_result=14 with o_valid at T+36; REMU 100 / 7 -> 2.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIV 7 / -2 -> 0xFFFFFFFD; REM 7 / -2 -> 1.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF / 0x80000000 -> 0x7FFFFFFF (exercises the msb path).
- DIV 5 / 0 -> 0xFFFFFFFF at T+1; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Hold i_ready=0 for 3 cycles in DONE -> o_result and o_rd_addr stable, o_ready=0; i_ready=1 -> IDLE next cycle. Changing inputs during ITER does not alter the result.
- i_flush at iteration 10 -> IDLE next cycle, no o_valid. i_rst_n=0 mid-ITER -> all outputs 0 next edge. A following DIVU 9/3 -> 3.
